// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : shared types for the ALU logic-unit sequencer           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_OR   = 2'b00,
    OP_NOR  = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } lu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    RESP  = 2'b10
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/logic_op_sequencer_settle_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | settle_timer : load/count-down timer, done when the count is zero |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("settle_timer: SETTLE_CYCLES must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at zero; the sequencer never asks for a decrement past it.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/logic_op_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | logic_op_sequencer : drives the 16-bit logic unit, captures result |
// | Optional operand chaining via macro LOGIC_SEQ_CHAIN_EN. Rev 1.0   |
// +------------------------------------------------------------------+
module logic_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
`ifdef LOGIC_SEQ_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_or,
  input  logic [WIDTH-1:0] lu_nor,
  input  logic [WIDTH-1:0] lu_xor,
  input  logic [WIDTH-1:0] lu_xnor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_parity
);

  seq_state_t       state_q, state_d;
  lu_op_t           op_q, op_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d, lu_b_q, lu_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             zero_q, zero_d, parity_q, parity_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             timer_load, timer_dec, timer_done;
  logic [WIDTH-1:0] sel_result;
  logic [WIDTH-1:0] a_src;
`ifdef LOGIC_SEQ_CHAIN_EN
  logic [WIDTH-1:0] last_q, last_d;
  assign a_src = cmd_chain ? last_q : cmd_a;
`else
  assign a_src = cmd_a;
`endif

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .done_o (timer_done)
  );

  always_comb begin
    sel_result = lu_or;
    case (op_q)
      OP_OR:   sel_result = lu_or;
      OP_NOR:  sel_result = lu_nor;
      OP_XOR:  sel_result = lu_xor;
      OP_XNOR: sel_result = lu_xnor;
      default: sel_result = lu_or;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    rsp_data_d  = rsp_data_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    rsp_valid_d = rsp_valid_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
`ifdef LOGIC_SEQ_CHAIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          lu_a_d     = a_src;
          lu_b_d     = cmd_b;
          op_d       = lu_op_t'(cmd_op);
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (timer_done) begin
          rsp_data_d  = sel_result;
          zero_d      = (sel_result == '0);
          parity_d    = ^sel_result;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef LOGIC_SEQ_CHAIN_EN
          last_d      = rsp_data_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered, so it reflects where the FSM is heading.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_OR;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      rsp_data_q  <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
`ifdef LOGIC_SEQ_CHAIN_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      rsp_data_q  <= rsp_data_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef LOGIC_SEQ_CHAIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign lu_a       = lu_a_q;
  assign lu_b       = lu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = zero_q;
  assign rsp_parity = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_sequencer.sv
`default_nettype none
// Bench for logic_op_sequencer: one instance with SETTLE_CYCLES=1, one with 4,
// each wired to a behavioural logic unit; results checked against a reference model.
module tb_logic_op_sequencer;

`ifdef LOGIC_SEQ_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cmd_valid1 = 1'b0, cmd_valid4 = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_chain = 1'b0;

  logic        cmd_ready1, rsp_valid1, rsp_zero1, rsp_parity1;
  logic [15:0] lu_a1, lu_b1, rsp_data1;
  logic        cmd_ready4, rsp_valid4, rsp_zero4, rsp_parity4;
  logic [15:0] lu_a4, lu_b4, rsp_data4;

  logic [15:0] lu_or1, lu_nor1, lu_xor1, lu_xnor1;
  logic [15:0] lu_or4, lu_nor4, lu_xor4, lu_xnor4;
  assign lu_or1 = lu_a1 | lu_b1;   assign lu_nor1  = ~(lu_a1 | lu_b1);
  assign lu_xor1 = lu_a1 ^ lu_b1;  assign lu_xnor1 = ~(lu_a1 ^ lu_b1);
  assign lu_or4 = lu_a4 | lu_b4;   assign lu_nor4  = ~(lu_a4 | lu_b4);
  assign lu_xor4 = lu_a4 ^ lu_b4;  assign lu_xnor4 = ~(lu_a4 ^ lu_b4);

  logic_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef LOGIC_SEQ_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .lu_a(lu_a1), .lu_b(lu_b1), .lu_or(lu_or1), .lu_nor(lu_nor1),
    .lu_xor(lu_xor1), .lu_xnor(lu_xnor1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_zero(rsp_zero1),
    .rsp_parity(rsp_parity1)
  );

  logic_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef LOGIC_SEQ_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .lu_a(lu_a4), .lu_b(lu_b4), .lu_or(lu_or4), .lu_nor(lu_nor4),
    .lu_xor(lu_xor4), .lu_xnor(lu_xnor4), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .rsp_zero(rsp_zero4),
    .rsp_parity(rsp_parity4)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] last1 = '0;

  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0: return a | b;
      2'd1: return ~(a | b);
      2'd2: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic ref_parity(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return (n % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command to the SETTLE_CYCLES=1 instance; returns after the accepting edge.
  task automatic send1(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic chain, output bit timeout);
    logic rdy;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid1 = 1'b1;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = cmd_ready1;
      tick();
      if (rdy) begin
        timeout = 1'b0;
        break;
      end
    end
    cmd_valid1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (cmd_ready1 !== 1'b0 || rsp_valid1 !== 1'b0 || cmd_ready4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b cmd_ready4=%b required 0 0 0", cmd_ready1, rsp_valid1, cmd_ready4);
    end
    checks++;
    if (rsp_data1 !== 16'h0 || lu_a1 !== 16'h0 || lu_b1 !== 16'h0 || rsp_zero1 !== 1'b0 || rsp_parity1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: data=%h lu_a=%h lu_b=%h z=%b p=%b required all 0", rsp_data1, lu_a1, lu_b1, rsp_zero1, rsp_parity1);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready1 !== 1'b1 || cmd_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b cmd_ready4=%b required 1 1", cmd_ready1, cmd_ready4);
    end
    last1 = '0;
  endtask

  task automatic test_directed_ops();
    logic [1:0]  ops [3] = '{2'd0, 2'd1, 2'd2};
    logic [15:0] as  [3] = '{16'h00F0, 16'hFFFF, 16'h0001};
    logic [15:0] bs  [3] = '{16'h0F00, 16'h0000, 16'h0000};
    logic [15:0] exps[3] = '{16'h0FF0, 16'h0000, 16'h0001};
    logic        zs  [3] = '{1'b0, 1'b1, 1'b0};
    logic        ps  [3] = '{1'b0, 1'b0, 1'b1};
    bit to;
    for (int i = 0; i < 3; i++) begin
      send1(ops[i], as[i], bs[i], 1'b0, to);
      checks++;
      if (to || lu_a1 !== as[i] || lu_b1 !== bs[i] || rsp_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL dir_accept[%0d]: timeout=%0d lu_a=%h lu_b=%h rsp_valid=%b required %h %h 0", i, to, lu_a1, lu_b1, rsp_valid1, as[i], bs[i]);
      end
      tick();
      checks++;
      if (rsp_valid1 !== 1'b1 || rsp_data1 !== exps[i] || rsp_zero1 !== zs[i] || rsp_parity1 !== ps[i]) begin
        failures++;
        $display("FAIL dir_result[%0d]: v=%b data=%h z=%b p=%b required 1 %h %b %b", i, rsp_valid1, rsp_data1, rsp_zero1, rsp_parity1, exps[i], zs[i], ps[i]);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      last1 = exps[i];
      checks++;
      if (rsp_valid1 !== 1'b0 || cmd_ready1 !== 1'b1) begin
        failures++;
        $display("FAIL dir_release[%0d]: rsp_valid=%b cmd_ready=%b required 0 1", i, rsp_valid1, cmd_ready1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad = 0;
    send1(2'd3, 16'hA5A5, 16'hA5A5, 1'b0, to);
    tick();
    cmd_op = 2'd0; cmd_a = 16'h1234; cmd_b = 16'h4321; cmd_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid1 !== 1'b1 || rsp_data1 !== 16'hFFFF || rsp_zero1 !== 1'b0 || rsp_parity1 !== 1'b0
          || cmd_ready1 !== 1'b0 || lu_a1 !== 16'hA5A5) bad++;
      tick();
    end
    checks++;
    if (to || bad != 0) begin
      failures++;
      $display("FAIL bp_hold: timeout=%0d bad_cycles=%0d last v=%b data=%h rdy=%b lu_a=%h required 1 FFFF 0 A5A5", to, bad, rsp_valid1, rsp_data1, cmd_ready1, lu_a1);
    end
    cmd_valid1 = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    last1 = 16'hFFFF;
    checks++;
    if (cmd_ready1 !== 1'b1 || rsp_valid1 !== 1'b0 || lu_a1 !== 16'hA5A5) begin
      failures++;
      $display("FAIL bp_release: cmd_ready=%b rsp_valid=%b lu_a=%h required 1 0 A5A5", cmd_ready1, rsp_valid1, lu_a1);
    end
  endtask

  task automatic test_settle4();
    logic [15:0] a, b, e;
    int bad = 0;
    a = 16'($urandom); b = 16'($urandom); e = a ^ b;
    cmd_op = 2'd2; cmd_a = a; cmd_b = b; cmd_chain = 1'b0; cmd_valid4 = 1'b1;
    tick();
    cmd_valid4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (rsp_valid4 !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || rsp_valid4 !== 1'b1 || rsp_data4 !== e || rsp_parity4 !== ref_parity(e)) begin
      failures++;
      $display("FAIL settle4_latency: early=%0d v=%b data=%h p=%b required 0 1 %h %b", bad, rsp_valid4, rsp_data4, rsp_parity4, e, ref_parity(e));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_valid4 = 1'b1;
    tick();
    cmd_valid4 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last1 = '0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid4 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || cmd_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL settle4_abort: valid_cycles=%0d cmd_ready4=%b required 0 1", bad, cmd_ready4);
    end
  endtask

  task automatic test_chain();
    bit to;
    send1(2'd0, 16'h0001, 16'h0002, 1'b0, to);
    tick();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    last1 = 16'h0003;
    send1(2'd2, 16'hFFFF, 16'h0001, 1'b1, to);
    checks++;
    if (to || lu_a1 !== 16'h0003) begin
      failures++;
      $display("FAIL chain_lu_a: timeout=%0d lu_a=%h required 0003", to, lu_a1);
    end
    tick();
    checks++;
    if (rsp_valid1 !== 1'b1 || rsp_data1 !== 16'h0002) begin
      failures++;
      $display("FAIL chain_result: v=%b data=%h required 1 0002", rsp_valid1, rsp_data1);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    last1 = 16'h0002;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] a, b, ea, e;
    logic        ch;
    int          stall, gap;
    bit          to;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = 16'($urandom); b = 16'($urandom);
      if (n % 7 == 0) b = ~a;
      ch = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      ea = (CHAIN_EN && ch) ? last1 : a;
      e = ref_result(op, ea, b);
      send1(op, a, b, ch, to);
      checks++;
      if (to || lu_a1 !== ea || lu_b1 !== b || rsp_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL rnd_accept[%0d]: timeout=%0d lu_a=%h lu_b=%h v=%b required %h %h 0", n, to, lu_a1, lu_b1, rsp_valid1, ea, b);
      end
      tick();
      checks++;
      if (rsp_valid1 !== 1'b1 || rsp_data1 !== e || rsp_zero1 !== (e == 16'h0) || rsp_parity1 !== ref_parity(e)) begin
        failures++;
        $display("FAIL rnd_result[%0d]: v=%b data=%h z=%b p=%b required 1 %h %b %b", n, rsp_valid1, rsp_data1, rsp_zero1, rsp_parity1, e, (e == 16'h0), ref_parity(e));
      end
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_data1 !== e || cmd_ready1 !== 1'b0) begin
          failures++;
          $display("FAIL rnd_stall[%0d]: v=%b data=%h rdy=%b required 1 %h 0", n, rsp_valid1, rsp_data1, cmd_ready1, e);
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      last1 = e;
      checks++;
      if (rsp_valid1 !== 1'b0 || cmd_ready1 !== 1'b1) begin
        failures++;
        $display("FAIL rnd_release[%0d]: v=%b rdy=%b required 0 1", n, rsp_valid1, cmd_ready1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_ops();
    test_backpressure();
    test_settle4();
`ifdef LOGIC_SEQ_CHAIN_EN
    test_chain();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
